// File: rtl/fetch_pkg.sv
// Shared types for the fetch unit: default widths, fetch FSM states, buffer entry.
// Latency: n/a (types only).
// Backpressure: n/a.
package fetch_pkg;

    localparam int FETCH_PC_W    = 10;
    localparam int FETCH_INSTR_W = 16;

    typedef enum logic [1:0] {
        ST_REQ     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_PC_W-1:0]    pc;
        logic [FETCH_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry in-order buffer of fetched {pc, instr} entries with synchronous flush.
// Latency: a push is visible at head the cycle after it is written.
// Backpressure: push is ignored when full unless a pop frees a slot the same cycle.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter type T = fetch_entry_t
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  T           push_data,
    input  logic       pop,
    input  logic       flush,
    output logic [1:0] count,
    output T           head
);

    T     mem [2];
    logic wr_ptr;
    logic rd_ptr;
    logic do_push;
    logic do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, 2-entry response buffer, redirect flush.
// Latency: response to instr_valid 1 cycle; 0 cycles into an empty buffer when FETCH_BYPASS_EN is defined.
// Backpressure: a request is only issued while the buffer has room for its response (occupancy < 2).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int PC_W    = FETCH_PC_W,
    parameter int INSTR_W = FETCH_INSTR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PC_W-1:0]    pc,
    output logic [PC_W-1:0]    next_pc,
    output logic               imem_req_valid,
    output logic [PC_W-1:0]    imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_data,
    output logic [PC_W-1:0]    instr_pc,
    input  logic               instr_ready
);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    fetch_state_t    state;
    logic [PC_W-1:0] req_pc;
    logic [1:0]      count;
    entry_t          head;
    entry_t          push_data;
    logic            accept;
    logic            rsp_in_wait;
    logic            buf_valid;
    logic            push;
    logic            pop;

    // Reserving a buffer slot before issuing guarantees the response always fits.
    assign imem_req_valid = !reset && (state == ST_REQ) && (count < 2'd2) && !redirect_valid;
    assign imem_req_addr  = pc;
    assign accept         = imem_req_valid && imem_req_ready;
    assign rsp_in_wait    = (state == ST_WAIT) && imem_rsp_valid && !redirect_valid;
    assign buf_valid      = (count != 2'd0);
    assign push_data      = '{pc: req_pc, instr: imem_rsp_data};
    assign pop            = buf_valid && instr_ready;

    always_comb begin
        next_pc = pc;
        if (reset) begin
            next_pc = '0;
        end else if (redirect_valid) begin
            next_pc = redirect_pc;
        end else if (accept) begin
            next_pc = pc + PC_W'(1);
        end
    end

`ifdef FETCH_BYPASS_EN
    logic bypass;

    assign bypass      = rsp_in_wait && !buf_valid;
    assign instr_valid = !reset && (buf_valid || bypass);
    assign instr_data  = reset ? '0 : (buf_valid ? head.instr : imem_rsp_data);
    assign instr_pc    = reset ? '0 : (buf_valid ? head.pc : req_pc);
    assign push        = rsp_in_wait && !(bypass && instr_ready);
`else
    assign instr_valid = !reset && buf_valid;
    assign instr_data  = reset ? '0 : head.instr;
    assign instr_pc    = reset ? '0 : head.pc;
    assign push        = rsp_in_wait;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_REQ;
            req_pc <= '0;
        end else begin
            case (state)
                ST_REQ: begin
                    if (accept) begin
                        state  <= ST_WAIT;
                        req_pc <= pc;
                    end
                end
                ST_WAIT: begin
                    // A redirect with no response yet leaves a stale response to swallow.
                    if (imem_rsp_valid) begin
                        state <= ST_REQ;
                    end else if (redirect_valid) begin
                        state <= ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    if (imem_rsp_valid) begin
                        state <= ST_REQ;
                    end
                end
                default: state <= ST_REQ;
            endcase
        end
    end

    fetch_buffer #(
        .T (entry_t)
    ) u_buffer (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (count),
        .head      (head)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: randomized memory/consumer/redirect traffic against a scoreboard model.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int PC_W = FETCH_PC_W;
    localparam int IW   = FETCH_INSTR_W;

    logic            clk = 1'b0;
    logic            reset;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] next_pc;
    logic            imem_req_valid;
    logic [PC_W-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [IW-1:0]   imem_rsp_data;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            instr_valid;
    logic [IW-1:0]   instr_data;
    logic [PC_W-1:0] instr_pc;
    logic            instr_ready;

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .pc             (pc),
        .next_pc        (next_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    always #5 clk = ~clk;

    // Program-counter register living outside the fetch unit.
    always @(posedge clk) pc <= next_pc;

    logic [IW-1:0]   mem [1<<PC_W];
    int              tests = 0;
    int              fails = 0;
    fetch_entry_t    exp_q[$];
    logic [PC_W-1:0] acc_log[$];
    logic [PC_W-1:0] seen_log[$];

    // Environment model state
    int              occ = 0;
    bit              outst = 0;
    bit              stale = 0;
    logic [PC_W-1:0] out_addr = '0;
    int              cd = 0;
    bit              flush_pend = 0;
    int              p_ready = 100;
    int              p_irdy = 100;
    int              redir_pct = 0;
    int              fixed_lat = 0;
    int              lat_max = 3;
    bit              force_redir = 0;
    logic [PC_W-1:0] force_pc = '0;
    bit              inject_rsp = 0;
    bit              rst_drive = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        bit              resp;
        bit              exp_req;
        bit              acc;
        bit              popped;
        logic [PC_W-1:0] exp_next;
        fetch_entry_t    e;
        @(posedge clk);
        if (flush_pend) begin
            exp_q.delete();
            flush_pend = 0;
        end
        #1;
        reset          = rst_drive;
        imem_req_ready = ($urandom_range(99) < p_ready);
        instr_ready    = ($urandom_range(99) < p_irdy);
        if (force_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = force_pc;
        end else begin
            redirect_valid = ($urandom_range(99) < redir_pct);
            redirect_pc    = PC_W'($urandom);
        end
        resp = !inject_rsp && outst && (cd == 0);
        if (inject_rsp) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = IW'($urandom);
        end else if (resp) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem[out_addr];
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = IW'($urandom);
        end
        @(negedge clk);
        if (reset) begin
            chk("rst_req_valid", imem_req_valid, 0);
            chk("rst_instr_valid", instr_valid, 0);
            chk("rst_instr_data", instr_data, 0);
            chk("rst_instr_pc", instr_pc, 0);
            chk("rst_next_pc", next_pc, 0);
            occ = 0; outst = 0; stale = 0; flush_pend = 1;
        end else begin
            exp_req = !outst && (occ < 2) && !redirect_valid;
            chk("req_valid", imem_req_valid, exp_req);
            if (imem_req_valid) chk("req_addr", imem_req_addr, pc);
            acc      = exp_req && imem_req_ready;
            exp_next = redirect_valid ? redirect_pc : (acc ? pc + 1'b1 : pc);
            chk("next_pc", next_pc, exp_next);
            chk("instr_valid", instr_valid, occ > 0);
            popped = (occ > 0) && instr_ready;
            if (redirect_valid) begin
                occ = 0;
                flush_pend = 1;
            end else if (popped) begin
                occ--;
            end
            if (resp) begin
                outst = 0;
                if (!stale && !redirect_valid) begin
                    e.pc = out_addr;
                    e.instr = mem[out_addr];
                    exp_q.push_back(e);
                    occ++;
                end
            end else if (outst) begin
                if (redirect_valid) stale = 1;
                if (cd > 0) cd--;
            end
            if (acc) begin
                outst = 1;
                stale = 0;
                out_addr = pc;
                cd = (fixed_lat >= 0) ? fixed_lat : $urandom_range(lat_max);
                acc_log.push_back(pc);
            end
        end
    endtask

    // Monitor: every instruction handed to the consumer must match the scoreboard head.
    initial begin
        fetch_entry_t e;
        forever begin
            @(negedge clk);
            if (!reset && instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_instr: got pc %0h, expected none", instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("instr_pc", instr_pc, e.pc);
                    chk("instr_data", instr_data, e.instr);
                end
                seen_log.push_back(instr_pc);
            end
        end
    end

    initial begin
        int              n0;
        int              k;
        logic [PC_W-1:0] a0;
        logic [PC_W-1:0] t;
        for (int i = 0; i < (1 << PC_W); i++) mem[i] = IW'($urandom);
        reset = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;

        repeat (3) cycle();
        rst_drive = 0;

        // Straight-line fetch, 1-cycle memory
        repeat (12) cycle();
        chk("acc_log_size", acc_log.size() >= 3, 1);
        chk("seen_log_size", seen_log.size() >= 3, 1);
        if (acc_log.size() >= 3 && seen_log.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("first_req_addr", acc_log[i], i);
                chk("first_instr_pc", seen_log[i], i);
            end
        end

        // Consumer stall: buffer fills to two and requests stop
        n0 = seen_log.size();
        p_irdy = 0;
        repeat (10) cycle();
        chk("stall_occ", occ, 2);
        chk("stall_instr_valid", instr_valid, 1);
        chk("stall_req_valid", imem_req_valid, 0);
        chk("stall_next_pc", next_pc, pc);
        chk("stall_no_pop", seen_log.size(), n0);
        p_irdy = 100;
        repeat (6) cycle();
        chk("drain_count", seen_log.size() >= n0 + 2, 1);
        if (seen_log.size() >= n0 + 2) begin
            t = seen_log[n0] + 1'b1;
            chk("drain_order", seen_log[n0+1], t);
        end

        // Redirect while waiting on memory with one buffered instruction
        p_irdy = 0; fixed_lat = 3;
        k = 0;
        while (!(occ == 1 && outst && cd > 0) && k < 40) begin cycle(); k++; end
        chk("reach_wait_bounded", k < 40, 1);
        force_redir = 1; force_pc = PC_W'(10'h200);
        cycle();
        chk("redir_next_pc", next_pc, 10'h200);
        force_redir = 0;
        cycle();
        chk("redir_flushed", instr_valid, 0);
        p_irdy = 100; fixed_lat = 0;
        n0 = seen_log.size();
        k = 0;
        while (seen_log.size() == n0 && k < 30) begin cycle(); k++; end
        chk("redir_instr_bounded", k < 30, 1);
        if (seen_log.size() > n0) chk("redir_instr_pc", seen_log[n0], 10'h200);

        // PC wrap at the top of the address space
        k = 0;
        while ((outst || occ >= 2) && k < 20) begin cycle(); k++; end
        force_redir = 1; force_pc = PC_W'(10'h3FF);
        cycle();
        force_redir = 0;
        cycle();
        chk("wrap_req_addr", imem_req_addr, 10'h3FF);
        chk("wrap_next_pc", next_pc, 0);
        repeat (6) cycle();

        // Memory not ready: request held stable
        k = 0;
        while ((outst || occ >= 2) && k < 20) begin cycle(); k++; end
        p_ready = 0;
        cycle();
        a0 = imem_req_addr;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) cycle();
            chk("hold_req_valid", imem_req_valid, 1);
            chk("hold_req_addr", imem_req_addr, a0);
            chk("hold_next_pc", next_pc, pc);
        end
        p_ready = 100;

        // Reset during WAIT, stale response right after release
        fixed_lat = 3;
        k = 0;
        while (!(outst && cd > 0) && k < 20) begin cycle(); k++; end
        rst_drive = 1;
        repeat (2) cycle();
        rst_drive = 0; p_ready = 0; inject_rsp = 1;
        cycle();
        inject_rsp = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("post_rst_instr_valid", instr_valid, 0);
        end
        p_ready = 100; fixed_lat = -1;

        // Randomized traffic
        p_ready = 70; p_irdy = 60; redir_pct = 5;
        repeat (3000) cycle();

        // Quiesce and confirm nothing was lost
        redir_pct = 0; p_irdy = 100; p_ready = 0;
        repeat (20) cycle();
        chk("final_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 10, program-counter width in words.
REQ-002 SHALL have parameter INSTR_W, default 16, instruction width.
REQ-003 SHALL have clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have pc  input  PC_W  current PC from the program-counter register.
REQ-006 SHALL have next_pc  output  PC_W  value loaded into the PC register next edge.
REQ-007 SHALL have imem_req_valid  output  1; imem_req_addr  output  PC_W; imem_req_ready  input  1.
REQ-008 SHALL have imem_rsp_valid  input  1; imem_rsp_data  input  INSTR_W.
REQ-009 SHALL have redirect_valid  input  1; redirect_pc  input  PC_W  (JALR/branch target).
REQ-010 SHALL have instr_valid  output  1; instr_data  output  INSTR_W; instr_pc  output  PC_W; instr_ready  input  1.

Function
REQ-011 SHALL drive imem_req_addr = pc whenever imem_req_valid is high.
REQ-012 SHALL allow at most one outstanding imem request; request accepted when imem_req_valid & imem_req_ready.
REQ-013 SHALL assert imem_req_valid only in state REQ, with (buffer occupancy) < 2, and redirect_valid low.
REQ-014 SHALL compute next_pc: redirect_valid -> redirect_pc; else request accepted -> pc+1 modulo 2^PC_W (1023 wraps to 0); else pc.
REQ-015 SHALL implement states REQ, WAIT, DISCARD: REQ->WAIT on accept; WAIT->REQ on imem_rsp_valid; WAIT->DISCARD on redirect_valid without same-cycle imem_rsp_valid; DISCARD->REQ on imem_rsp_valid.
REQ-016 SHALL push {pc of issued request, imem_rsp_data} into a 2-entry buffer on imem_rsp_valid in WAIT; SHALL drop responses in DISCARD.
REQ-017 SHALL hold imem_req_valid and imem_req_addr stable until accepted unless redirect_valid occurs.
REQ-018 SHALL present buffer head on instr_valid/instr_data/instr_pc; pop when instr_valid & instr_ready; push and pop in the same cycle SHALL keep occupancy unchanged.
REQ-019 SHALL, on redirect_valid, flush the buffer (instr_valid low next cycle) and drop a same-cycle imem_rsp_valid in WAIT, entering REQ.
REQ-020 SHALL give response-to-instr_valid latency of 1 cycle (without bypass), and ignore imem_rsp_valid in REQ.
REQ-021 SHALL never overflow: reservation rule of REQ-013 guarantees space for every in-flight response.

Reset
REQ-022 SHALL on reset enter REQ, empty the buffer, clear the captured request PC.
REQ-023 SHALL hold imem_req_valid=0, instr_valid=0, instr_data=0, instr_pc=0, next_pc=0 while reset is high.
REQ-024 SHALL abandon any outstanding request on reset; a response arriving in the first cycle after reset is ignored.

Configuration
REQ-025 SHALL support macro FETCH_BYPASS_EN: when defined, imem_rsp_valid with an empty buffer drives instr_valid/instr_data/instr_pc combinationally the same cycle, with no push if instr_ready is high; when undefined, all output comes from the buffer (REQ-020).

Structure
REQ-026 SHALL place PC_W/INSTR_W defaults, the fetch state enum and the buffer-entry struct {pc, instr} in shared package fetch_pkg.
REQ-027 SHALL implement the 2-entry buffer as sub-module fetch_buffer (push, pop, flush, count, head outputs).

Verification
REQ-028 Reset with pc=0, imem_req_ready=1, 1-cycle memory -> after reset release: req addrs 0,1,2..., next_pc increments, instr_pc 0,1,2 with data matching memory.
REQ-029 instr_ready=0 for 10 cycles -> exactly 2 instructions buffered, imem_req_valid low, next_pc==pc; resume -> in-order drain, no loss or duplicate.
REQ-030 redirect_valid with redirect_pc=0x200 while in WAIT -> next_pc=0x200, buffer empties, stale response dropped, next instr_pc=0x200.
REQ-031 pc=0x3FF accepted -> next_pc=0x000.
REQ-032 imem_req_ready low 5 cycles -> imem_req_addr stable, next_pc==pc throughout.
REQ-033 reset asserted mid-WAIT, response returned 1 cycle after release -> response ignored, instr_valid stays 0.
